// File: rtl/dec_pkg.sv
// Shared definitions for the one-hot decoder/sequencer: FSM state encoding and mode values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dec_pkg;

    localparam logic [1:0] IDLE_ENC   = 2'b00;
    localparam logic [1:0] DIRECT_ENC = 2'b01;
    localparam logic [1:0] SCAN_ENC   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE_ENC,
        ST_DIRECT = DIRECT_ENC,
        ST_SCAN   = SCAN_ENC
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_dwell_timer.sv
// Dwell down-counter: load/reload with a hold count, decrement on request, zero flag.
// Latency: load/decrement take effect at the next clock edge; zero is combinational from the count.
// Backpressure: none; load has priority over decrement.
// Ports: clk, rst (sync, active-high), load, load_val, dec, zero.
module dec_dwell_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_dec_seq.sv
// Registered SEL_W-to-OUT_W one-hot decoder: DIRECT decodes each accepted select, SCAN walks all lines with a dwell.
// Latency: accepted transfer -> y/y_valid one edge later; scan advances once per dwell+1 cycles.
// Backpressure: in_ready = en & not scanning; en=0 forces IDLE with all-zero output on the next edge.
// Ports: clk, rst (sync, active-high), en, mode, in_valid, in_ready, sel, dwell -> y, y_valid, scan_wrap.
// Build option DEC_TRISTATE_EN: y floats ('z) whenever y_valid=0 instead of driving zero.
module onehot_dec_seq
    import dec_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 1 << SEL_W,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   y,
    output logic               y_valid,
    output logic               scan_wrap
);

    localparam logic [SEL_W:0]   OUT_W_C  = (SEL_W+1)'(OUT_W);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] one;
        one = OUT_W'(1);
        return one << i;
    endfunction

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [OUT_W-1:0]     y_q, y_d;
    logic                 y_valid_d;
    logic                 scan_wrap_d;
    logic [DWELL_W-1:0]   dwell_lat_q, dwell_lat_d;
    logic                 timer_load;
    logic [DWELL_W-1:0]   timer_load_val;
    logic                 timer_dec;
    logic                 timer_zero;

    logic                 accept;
    logic                 sel_ok;
    logic [SEL_W-1:0]     scan_start;
    logic [SEL_W-1:0]     scan_next;

    assign in_ready   = en && (state_q != ST_SCAN);
    assign accept     = in_valid && in_ready;
    assign sel_ok     = ({1'b0, sel} < OUT_W_C);
    // An out-of-range start index begins the scan at line 0.
    assign scan_start = sel_ok ? sel : '0;
    assign scan_next  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        y_d            = y_q;
        y_valid_d      = y_valid;
        scan_wrap_d    = 1'b0;
        dwell_lat_d    = dwell_lat_q;
        timer_load     = 1'b0;
        timer_load_val = dwell;
        timer_dec      = 1'b0;

        if (!en) begin
            state_d   = ST_IDLE;
            idx_d     = '0;
            y_d       = '0;
            y_valid_d = 1'b0;
        end else if (accept) begin
            if (mode == MODE_SCAN) begin
                state_d        = ST_SCAN;
                idx_d          = scan_start;
                y_d            = onehot(scan_start);
                y_valid_d      = 1'b1;
                dwell_lat_d    = dwell;
                timer_load     = 1'b1;
                timer_load_val = dwell;
            end else begin
                state_d = ST_DIRECT;
                if (sel_ok) begin
                    idx_d     = sel;
                    y_d       = onehot(sel);
                    y_valid_d = 1'b1;
                end else begin
                    y_d       = '0;
                    y_valid_d = 1'b0;
                end
            end
        end else if (state_q == ST_SCAN) begin
            if (timer_zero) begin
                idx_d          = scan_next;
                y_d            = onehot(scan_next);
                scan_wrap_d    = (idx_q == LAST_IDX);
                timer_load     = 1'b1;
                timer_load_val = dwell_lat_q;
            end else begin
                timer_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            y_q         <= '0;
            y_valid     <= 1'b0;
            scan_wrap   <= 1'b0;
            dwell_lat_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            y_q         <= y_d;
            y_valid     <= y_valid_d;
            scan_wrap   <= scan_wrap_d;
            dwell_lat_q <= dwell_lat_d;
        end
    end

    dec_dwell_timer #(
        .W(DWELL_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

`ifdef DEC_TRISTATE_EN
    assign y = y_valid ? y_q : {OUT_W{1'bz}};
`else
    assign y = y_q;
`endif

endmodule
